mic_2r1c: RTL and testbench



---
 rtl/mic_2r1c.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_mic_2r1c.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_2r1c.sv
// mic_2r1c: two-requester / one-completer packet interconnect.
//
// Request path: requester packets (R0I_*, R1I_*) are arbitrated onto the
// completer request port (C0O_*). The header beat (first beat of a packet) has
// TDATA[ROUTE_BIT] overwritten with the granted requester index. A 2-entry
// registered skid stage drives C0O_*.
// Response path: completer responses (C0I_*) are steered combinationally to
// R0O_* or R1O_* according to the echoed header TDATA[ROUTE_BIT].
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   R0I_*, R1I_*       requester request inputs  (TVALID/TREADY/TDATA/TLAST)
//   R0O_*, R1O_*       requester response outputs
//   C0O_*              completer request output (registered)
//   C0I_*              completer response input
//
// Configuration macro: MIC_2R1C_ROUNDROBIN_EN selects round-robin arbitration;
// when undefined, R0 has fixed priority.
module mic_2r1c #(
    parameter int unsigned ROUTE_BIT = 63
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        R0I_TVALID,
    output logic        R0I_TREADY,
    input  logic [63:0] R0I_TDATA,
    input  logic        R0I_TLAST,

    output logic        R0O_TVALID,
    input  logic        R0O_TREADY,
    output logic [63:0] R0O_TDATA,
    output logic        R0O_TLAST,

    input  logic        R1I_TVALID,
    output logic        R1I_TREADY,
    input  logic [63:0] R1I_TDATA,
    input  logic        R1I_TLAST,

    output logic        R1O_TVALID,
    input  logic        R1O_TREADY,
    output logic [63:0] R1O_TDATA,
    output logic        R1O_TLAST,

    output logic        C0O_TVALID,
    input  logic        C0O_TREADY,
    output logic [63:0] C0O_TDATA,
    output logic        C0O_TLAST,

    input  logic        C0I_TVALID,
    output logic        C0I_TREADY,
    input  logic [63:0] C0I_TDATA,
    input  logic        C0I_TLAST
);

    localparam int unsigned DW = 64;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    localparam logic [1:0] RIDLE = 2'd0;
    localparam logic [1:0] RSP0  = 2'd1;
    localparam logic [1:0] RSP1  = 2'd2;

    // ---------------------------------------------------------------------
    // Request path state
    // ---------------------------------------------------------------------
    logic [1:0]    arb_q, arb_d;
    logic          hdr_q, hdr_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          skid_last_q, skid_last_d;
`ifdef MIC_2R1C_ROUNDROBIN_EN
    logic          rr_q, rr_d;
`endif

    logic          pick_c;
    logic          gnt_c;
    logic          gnt_act_c;
    logic          in_valid_c;
    logic [DW-1:0] in_data_c;
    logic          in_last_c;
    logic [DW-1:0] tag_data_c;
    logic          full_c;
    logic          in_ready_c;
    logic          push_c;
    logic          pop_c;
    logic          out_free_c;

    // Winner of a fresh arbitration in IDLE (only meaningful if any valid)
    always_comb begin : arb_pick
`ifdef MIC_2R1C_ROUNDROBIN_EN
        if (R0I_TVALID && R1I_TVALID) begin
            pick_c = rr_q;
        end else begin
            pick_c = R1I_TVALID;
        end
`else
        pick_c = !R0I_TVALID;
`endif
    end

    // Arbiter FSM next state plus request datapath selection and skid control
    always_comb begin : arb_fsm
        arb_d        = arb_q;
        hdr_d        = hdr_q;
        gnt_c        = 1'b0;
        gnt_act_c    = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
`ifdef MIC_2R1C_ROUNDROBIN_EN
        rr_d         = rr_q;
`endif

        case (arb_q)
            IDLE: begin
                gnt_c     = pick_c;
                gnt_act_c = R0I_TVALID || R1I_TVALID;
            end
            GRANT0: begin
                gnt_c     = 1'b0;
                gnt_act_c = 1'b1;
            end
            GRANT1: begin
                gnt_c     = 1'b1;
                gnt_act_c = 1'b1;
            end
            default: begin
                gnt_c     = 1'b0;
                gnt_act_c = 1'b0;
            end
        endcase

        in_valid_c = gnt_c ? R1I_TVALID : R0I_TVALID;
        in_data_c  = gnt_c ? R1I_TDATA  : R0I_TDATA;
        in_last_c  = gnt_c ? R1I_TLAST  : R0I_TLAST;

        // Header beat carries the granted index in the route bit
        tag_data_c = in_data_c;
        if (hdr_q) begin
            tag_data_c[ROUTE_BIT] = gnt_c;
        end

        full_c     = out_valid_q && skid_valid_q;
        in_ready_c = gnt_act_c && !full_c;
        push_c     = in_valid_c && in_ready_c;
        pop_c      = out_valid_q && C0O_TREADY;
        out_free_c = !out_valid_q || pop_c;

        // Skid entry is always older than the incoming beat
        if (out_free_c) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = push_c;
                if (push_c) begin
                    skid_data_d = tag_data_c;
                    skid_last_d = in_last_c;
                end
            end else begin
                out_valid_d = push_c;
                if (push_c) begin
                    out_data_d = tag_data_c;
                    out_last_d = in_last_c;
                end
            end
        end else if (push_c) begin
            skid_valid_d = 1'b1;
            skid_data_d  = tag_data_c;
            skid_last_d  = in_last_c;
        end

        if (push_c) begin
            hdr_d = in_last_c;
        end

        // Grant is held until the TLAST beat is accepted
        if (gnt_act_c) begin
            if (push_c && in_last_c) begin
                arb_d = IDLE;
`ifdef MIC_2R1C_ROUNDROBIN_EN
                rr_d  = !gnt_c;
`endif
            end else begin
                arb_d = gnt_c ? GRANT1 : GRANT0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response path state
    // ---------------------------------------------------------------------
    logic [1:0] rsp_q, rsp_d;
    logic       rsp_sel_c;
    logic       rsp_act_c;
    logic       rsp_rdy_c;
    logic       rsp_hs_c;
    logic       r0o_valid_c;
    logic       r1o_valid_c;

    // Response steer FSM; header is steered in the same cycle it appears
    always_comb begin : rsp_fsm
        rsp_d     = rsp_q;
        rsp_sel_c = 1'b0;
        rsp_act_c = 1'b0;

        case (rsp_q)
            RIDLE: begin
                rsp_sel_c = C0I_TDATA[ROUTE_BIT];
                rsp_act_c = C0I_TVALID;
            end
            RSP0: begin
                rsp_sel_c = 1'b0;
                rsp_act_c = 1'b1;
            end
            RSP1: begin
                rsp_sel_c = 1'b1;
                rsp_act_c = 1'b1;
            end
            default: begin
                rsp_sel_c = 1'b0;
                rsp_act_c = 1'b0;
            end
        endcase

        rsp_rdy_c = rsp_sel_c ? R1O_TREADY : R0O_TREADY;
        rsp_hs_c  = rsp_act_c && C0I_TVALID && rsp_rdy_c;

        if (rsp_act_c && C0I_TVALID) begin
            if (rsp_hs_c && C0I_TLAST) begin
                rsp_d = RIDLE;
            end else begin
                rsp_d = rsp_sel_c ? RSP1 : RSP0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_q        <= IDLE;
            hdr_q        <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            rsp_q        <= RIDLE;
`ifdef MIC_2R1C_ROUNDROBIN_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            arb_q        <= arb_d;
            hdr_q        <= hdr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            rsp_q        <= rsp_d;
`ifdef MIC_2R1C_ROUNDROBIN_EN
            rr_q         <= rr_d;
`endif
        end
    end

    // Combinational outputs are forced low while reset is asserted
    assign R0I_TREADY = reset && in_ready_c && !gnt_c;
    assign R1I_TREADY = reset && in_ready_c &&  gnt_c;

    assign C0O_TVALID = out_valid_q;
    assign C0O_TDATA  = out_data_q;
    assign C0O_TLAST  = out_last_q;

    assign r0o_valid_c = reset && rsp_act_c && C0I_TVALID && !rsp_sel_c;
    assign r1o_valid_c = reset && rsp_act_c && C0I_TVALID &&  rsp_sel_c;

    assign R0O_TVALID = r0o_valid_c;
    assign R0O_TDATA  = r0o_valid_c ? C0I_TDATA : '0;
    assign R0O_TLAST  = r0o_valid_c && C0I_TLAST;

    assign R1O_TVALID = r1o_valid_c;
    assign R1O_TDATA  = r1o_valid_c ? C0I_TDATA : '0;
    assign R1O_TLAST  = r1o_valid_c && C0I_TLAST;

    assign C0I_TREADY = reset && rsp_act_c && rsp_rdy_c;

endmodule

// File: tb/tb_mic_2r1c.sv
// Scoreboard bench for mic_2r1c: drivers push expected beats per destination,
// negedge monitors pop and compare whenever an output handshake occurs.
`timescale 1ns/1ps
module tb_mic_2r1c;

    logic        clk;
    logic        reset;

    logic [1:0]  rq_valid;
    logic [1:0]  rq_ready;
    logic [63:0] rq_data [2];
    logic [1:0]  rq_last;

    logic [1:0]  ro_valid;
    logic [1:0]  ro_ready;
    logic [63:0] ro_data0, ro_data1;
    logic [1:0]  ro_last;

    logic        c0o_valid, c0o_ready, c0o_last;
    logic [63:0] c0o_data;
    logic        c0i_valid, c0i_ready, c0i_last;
    logic [63:0] c0i_data;

    mic_2r1c #(.ROUTE_BIT(63)) dut (
        .clk(clk), .reset(reset),
        .R0I_TVALID(rq_valid[0]), .R0I_TREADY(rq_ready[0]), .R0I_TDATA(rq_data[0]), .R0I_TLAST(rq_last[0]),
        .R0O_TVALID(ro_valid[0]), .R0O_TREADY(ro_ready[0]), .R0O_TDATA(ro_data0), .R0O_TLAST(ro_last[0]),
        .R1I_TVALID(rq_valid[1]), .R1I_TREADY(rq_ready[1]), .R1I_TDATA(rq_data[1]), .R1I_TLAST(rq_last[1]),
        .R1O_TVALID(ro_valid[1]), .R1O_TREADY(ro_ready[1]), .R1O_TDATA(ro_data1), .R1O_TLAST(ro_last[1]),
        .C0O_TVALID(c0o_valid), .C0O_TREADY(c0o_ready), .C0O_TDATA(c0o_data), .C0O_TLAST(c0o_last),
        .C0I_TVALID(c0i_valid), .C0I_TREADY(c0i_ready), .C0I_TDATA(c0i_data), .C0I_TLAST(c0i_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues: {last, data}
    logic [64:0] exp_c0_0[$];
    logic [64:0] exp_c0_1[$];
    logic [64:0] exp_ro_0[$];
    logic [64:0] exp_ro_1[$];
    int          got_order[$];
    int          acc_cyc[$];
    bit          lat_en = 1'b0;
    int          acc_n0 = 0;

    int          c0_mode = 0;   // 0 ready, 1 random, 2 stalled
    int          ro_mode = 0;   // 0 ready, 1 toggling, 2 random
    int          rsp_dst = 0;
    bit          rsp_active = 1'b0;
    bit          rsp_first = 1'b0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ready generators
    initial begin
        c0o_ready = 1'b1;
        ro_ready  = 2'b11;
        forever begin
            step();
            case (c0_mode)
                0: c0o_ready = 1'b1;
                1: c0o_ready = ($urandom_range(3, 0) != 0);
                default: c0o_ready = 1'b0;
            endcase
            case (ro_mode)
                0: ro_ready = 2'b11;
                1: ro_ready = ~ro_ready;
                default: ro_ready = 2'($urandom_range(3, 0));
            endcase
        end
    end

    // Request driver: expected tagged beats are queued before driving
    task automatic send_req(input int r, input int nb, input int gap,
                            input bit use_hdr, input logic [63:0] hdr);
        logic [63:0] beats[$];
        logic [64:0] e;
        bit hs;
        for (int i = 0; i < nb; i++) begin
            beats.push_back((i == 0 && use_hdr) ? hdr : {$urandom, $urandom});
            e = {(i == nb - 1), beats[i]};
            if (i == 0) e[63] = r[0];
            if (r == 0) exp_c0_0.push_back(e); else exp_c0_1.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(gap, 0)) step();
            rq_valid[r] = 1'b1;
            rq_data[r]  = beats[i];
            rq_last[r]  = (i == nb - 1);
            do begin
                @(negedge clk);
                hs = rq_ready[r] && reset;
                if (hs && lat_en) acc_cyc.push_back(cyc);
                if (hs && r == 0) acc_n0++;
                step();
            end while (!hs);
            rq_valid[r] = 1'b0;
        end
    endtask

    // Response driver: header route bit names the destination
    task automatic send_rsp(input int dst, input int nb, input int gap);
        logic [63:0] beats[$];
        logic [63:0] d;
        bit hs;
        for (int i = 0; i < nb; i++) begin
            d = {$urandom, $urandom};
            if (i == 0) d[63] = dst[0];
            beats.push_back(d);
            if (dst == 0) exp_ro_0.push_back({(i == nb - 1), d});
            else          exp_ro_1.push_back({(i == nb - 1), d});
        end
        rsp_dst = dst;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(gap, 0)) step();
            c0i_valid  = 1'b1;
            c0i_data   = beats[i];
            c0i_last   = (i == nb - 1);
            rsp_first  = (i == 0);
            rsp_active = 1'b1;
            do begin
                @(negedge clk);
                hs = c0i_ready && reset;
                step();
            end while (!hs);
            c0i_valid  = 1'b0;
            rsp_active = 1'b0;
        end
    endtask

    // C0O monitor
    bit          c0_in_pkt = 1'b0;
    int          c0_src = 0;
    bit          stall_prev = 1'b0;
    logic [64:0] prev_beat;
    int          a;
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                chk("c0o_hold_valid", 65'(c0o_valid), 65'd1);
                chk("c0o_hold_beat", {c0o_last, c0o_data}, prev_beat);
            end
            if (c0o_valid && c0o_ready) begin
                if (!c0_in_pkt) begin
                    c0_src = int'(c0o_data[63]);
                    got_order.push_back(c0_src);
                end
                if ((c0_src == 0 && exp_c0_0.size() == 0) || (c0_src == 1 && exp_c0_1.size() == 0)) begin
                    chk("c0o_unexpected_beat", {c0o_last, c0o_data}, 65'd0);
                end else if (c0_src == 0) begin
                    chk("c0o_beat_r0", {c0o_last, c0o_data}, exp_c0_0.pop_front());
                end else begin
                    chk("c0o_beat_r1", {c0o_last, c0o_data}, exp_c0_1.pop_front());
                end
                if (lat_en && acc_cyc.size() != 0) begin
                    a = acc_cyc.pop_front();
                    chk("c0o_latency", 65'(cyc), 65'(a + 1));
                end
                c0_in_pkt = !c0o_last;
            end
            chk("rq_ready_exclusive", 65'(rq_ready[0] && rq_ready[1]), 65'd0);
            stall_prev = c0o_valid && !c0o_ready;
            prev_beat  = {c0o_last, c0o_data};
        end else begin
            c0_in_pkt  = 1'b0;
            stall_prev = 1'b0;
        end
    end

    // Response monitors
    always @(negedge clk) begin
        if (reset) begin
            if (c0i_valid && rsp_active) begin
                chk("c0i_ready_track", 65'(c0i_ready), 65'(ro_ready[rsp_dst]));
                chk("ro_other_quiet", 65'(ro_valid[1 - rsp_dst]), 65'd0);
                if (!rsp_first) chk("ro_no_bubble", 65'(ro_valid[rsp_dst]), 65'd1);
            end
            if (ro_valid[0] && ro_ready[0]) begin
                if (exp_ro_0.size() == 0) chk("r0o_unexpected_beat", {ro_last[0], ro_data0}, 65'd0);
                else chk("r0o_beat", {ro_last[0], ro_data0}, exp_ro_0.pop_front());
            end
            if (ro_valid[1] && ro_ready[1]) begin
                if (exp_ro_1.size() == 0) chk("r1o_unexpected_beat", {ro_last[1], ro_data1}, 65'd0);
                else chk("r1o_beat", {ro_last[1], ro_data1}, exp_ro_1.pop_front());
            end
        end
    end

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_c0_0.size() + exp_c0_1.size() + exp_ro_0.size() + exp_ro_1.size()) != 0 && t < 2000) begin
            step();
            t++;
        end
        chk(name, 65'(exp_c0_0.size() + exp_c0_1.size() + exp_ro_0.size() + exp_ro_1.size()), 65'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_c0o_valid"}, 65'(c0o_valid), 65'd0);
        chk({tag, "_c0o_beat"}, {c0o_last, c0o_data}, 65'd0);
        chk({tag, "_rq_ready"}, 65'(rq_ready), 65'd0);
        chk({tag, "_ro_valid"}, 65'(ro_valid), 65'd0);
        chk({tag, "_ro_data"}, 65'(ro_data0 | ro_data1), 65'd0);
        chk({tag, "_ro_last"}, 65'(ro_last), 65'd0);
        chk({tag, "_c0i_ready"}, 65'(c0i_ready), 65'd0);
    endtask

    // Watchdog
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    localparam int K = 4;
    int exp_order[$];
    int n0, n1, turn;

    initial begin
        reset     = 1'b0;
        rq_valid  = 2'b11;
        rq_last   = 2'b00;
        rq_data[0] = 64'h1;
        rq_data[1] = 64'h2;
        c0i_valid = 1'b1;
        c0i_data  = 64'hffff_ffff_ffff_ffff;
        c0i_last  = 1'b1;
        repeat (3) step();
        // Inputs asserted during reset must not leak to any output
        check_outputs_zero("reset_init");
        rq_valid  = 2'b00;
        c0i_valid = 1'b0;
        c0i_data  = '0;
        c0i_last  = 1'b0;
        reset     = 1'b1;
        repeat (2) step();

        // Single 3-beat packet from R0, one-cycle latency
        lat_en = 1'b1;
        send_req(0, 3, 0, 1'b1, 64'h0000_0000_1000_0000);
        drain("t1_drain");
        // Single-beat packet from R1, header gains route bit
        send_req(1, 1, 0, 1'b1, 64'h0000_0000_2000_0040);
        drain("t2_drain");
        lat_en = 1'b0;
        acc_cyc.delete();

        // Contention: both requesters continuously valid, 2-beat packets
        got_order.delete();
        fork
            for (int i = 0; i < K; i++) send_req(0, 2, 0, 1'b0, 64'd0);
            for (int i = 0; i < K; i++) send_req(1, 2, 0, 1'b0, 64'd0);
        join
        drain("t3_drain");
        n0 = K; n1 = K; turn = 0;
        exp_order.delete();
        while (n0 + n1 > 0) begin
`ifdef MIC_2R1C_ROUNDROBIN_EN
            if ((turn == 0 && n0 > 0) || n1 == 0) begin exp_order.push_back(0); n0--; turn = 1; end
            else begin exp_order.push_back(1); n1--; turn = 0; end
`else
            if (n0 > 0) begin exp_order.push_back(0); n0--; end
            else begin exp_order.push_back(1); n1--; end
`endif
        end
        chk("arb_order_len", 65'(got_order.size()), 65'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < got_order.size(); i++)
            chk("arb_order", 65'(got_order[i]), 65'(exp_order[i]));

        // Response to R1 with toggling ready
        ro_mode = 1;
        send_rsp(1, 4, 0);
        drain("t4_drain");
        ro_mode = 0;

        // Completer stalled for 5 cycles during a 4-beat R0 packet
        c0_mode = 2;
        step();
        acc_n0 = 0;
        fork
            send_req(0, 4, 0, 1'b0, 64'd0);
            begin
                repeat (5) step();
                @(negedge clk);
                chk("stall_accepted_beats", 65'(acc_n0), 65'd2);
                chk("stall_r0_ready_low", 65'(rq_ready[0]), 65'd0);
                step();
                c0_mode = 0;
            end
        join
        drain("t5_drain");

        // Asynchronous reset in the middle of a packet
        c0_mode = 2;
        step();
        rq_valid[0] = 1'b1;
        rq_data[0]  = {$urandom, $urandom};
        rq_last[0]  = 1'b0;
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        rq_valid = 2'b00;
        c0_mode  = 0;
        reset    = 1'b1;
        step();
        got_order.delete();
        send_req(1, 3, 0, 1'b1, 64'h0123_4567_89ab_cdef);
        drain("t6_drain");
        chk("t6_route_r1", 65'(got_order.size() == 1 ? got_order[0] : -1), 65'd1);

        // Randomized concurrent traffic on both paths
        c0_mode = 1;
        ro_mode = 2;
        fork
            for (int i = 0; i < 20; i++) send_req(0, $urandom_range(4, 1), 2, 1'b0, 64'd0);
            for (int i = 0; i < 20; i++) send_req(1, $urandom_range(4, 1), 2, 1'b0, 64'd0);
            for (int i = 0; i < 20; i++) send_rsp($urandom_range(1, 0), $urandom_range(4, 1), 2);
        join
        c0_mode = 0;
        ro_mode = 0;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
